// File: rtl/stopwatch_ctrl_if.sv
// Button levels in, tick/run status and BCD display digits out for stopwatch_ctrl.
// master = button/display side, slave = the controller.
interface stopwatch_ctrl_if;
  localparam int unsigned DIGIT_W = 4;

  logic               start;
  logic               pause;
  logic               clear;
  logic               lap;
  logic               tick_1hz;
  logic               running;
  logic               wrap;
  logic               lap_hold;
  logic [DIGIT_W-1:0] sec_u;
  logic [DIGIT_W-1:0] sec_t;
  logic [DIGIT_W-1:0] min_u;
  logic [DIGIT_W-1:0] min_t;

  modport master (
    output start, pause, clear, lap,
    input  tick_1hz, running, wrap, lap_hold, sec_u, sec_t, min_u, min_t
  );

  modport slave (
    input  start, pause, clear, lap,
    output tick_1hz, running, wrap, lap_hold, sec_u, sec_t, min_u, min_t
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button event capture, 1 Hz prescaler, run/pause FSM, BCD MM:SS count.
// Define STOPWATCH_LAP_EN to enable the lap/hold display freeze.
module stopwatch_ctrl #(
  parameter int unsigned DIV   = 50000000,
  parameter int unsigned PRE_W = 26
) (
  input  logic            clk,
  input  logic            rst,
  stopwatch_ctrl_if.slave sw
);
  localparam int unsigned DIG_W = 4;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } state_t;

  state_t           r_state;
  logic [PRE_W-1:0] r_pre;
  logic             r_tick;
  logic             r_wrap;
  logic             r_running;
  logic             r_lap_hold;

  logic             r_start_prev, r_pause_prev, r_clear_prev;
  logic             r_start_evt,  r_pause_evt,  r_clear_evt;

  logic [DIG_W-1:0] r_su, r_st, r_mu, r_mt;
  logic [DIG_W-1:0] r_dsu, r_dst, r_dmu, r_dmt;

  logic             w_do_tick;
  logic             w_hold_nxt;
  logic             w_wrap_inc;
  logic [DIG_W-1:0] w_su_inc, w_st_inc, w_mu_inc, w_mt_inc;
  logic [DIG_W-1:0] w_su_nxt, w_st_nxt, w_mu_nxt, w_mt_nxt;

  // Edge history resets high so a button held through reset never fires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start_prev <= 1'b1;
      r_pause_prev <= 1'b1;
      r_clear_prev <= 1'b1;
      r_start_evt  <= 1'b0;
      r_pause_evt  <= 1'b0;
      r_clear_evt  <= 1'b0;
    end else begin
      r_start_prev <= sw.start;
      r_pause_prev <= sw.pause;
      r_clear_prev <= sw.clear;
      r_start_evt  <= sw.start & ~r_start_prev;
      r_pause_evt  <= sw.pause & ~r_pause_prev;
      r_clear_evt  <= sw.clear & ~r_clear_prev;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic r_lap_prev;
  logic r_lap_evt;
  logic w_lap_toggle;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lap_prev <= 1'b1;
      r_lap_evt  <= 1'b0;
    end else begin
      r_lap_prev <= sw.lap;
      r_lap_evt  <= sw.lap & ~r_lap_prev;
    end
  end

  assign w_lap_toggle = r_lap_evt && ((r_state == ST_RUN) || (r_state == ST_PAUSED));
  assign w_hold_nxt   = r_lap_hold ^ w_lap_toggle;
`else
  logic w_lap_unused;
  assign w_lap_unused = sw.lap;
  assign w_hold_nxt   = 1'b0;
`endif

  // A pause event in the terminal-count cycle wins over the tick.
  assign w_do_tick = (r_state == ST_RUN) && !r_clear_evt && !r_pause_evt && (r_pre == PRE_LAST);

  // BCD +1 with ripple carry; wrap flags the 59:59 -> 00:00 rollover.
  always_comb begin
    w_su_inc   = r_su;
    w_st_inc   = r_st;
    w_mu_inc   = r_mu;
    w_mt_inc   = r_mt;
    w_wrap_inc = 1'b0;
    if (r_su == DIG_W'(9)) begin
      w_su_inc = '0;
      if (r_st == DIG_W'(5)) begin
        w_st_inc = '0;
        if (r_mu == DIG_W'(9)) begin
          w_mu_inc = '0;
          if (r_mt == DIG_W'(5)) begin
            w_mt_inc   = '0;
            w_wrap_inc = 1'b1;
          end else begin
            w_mt_inc = r_mt + DIG_W'(1);
          end
        end else begin
          w_mu_inc = r_mu + DIG_W'(1);
        end
      end else begin
        w_st_inc = r_st + DIG_W'(1);
      end
    end else begin
      w_su_inc = r_su + DIG_W'(1);
    end
  end

  assign w_su_nxt = w_do_tick ? w_su_inc : r_su;
  assign w_st_nxt = w_do_tick ? w_st_inc : r_st;
  assign w_mu_nxt = w_do_tick ? w_mu_inc : r_mu;
  assign w_mt_nxt = w_do_tick ? w_mt_inc : r_mt;

  // Run/pause FSM owning the prescaler and the tick/wrap/running outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_pre     <= '0;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_tick <= w_do_tick;
      r_wrap <= w_do_tick & w_wrap_inc;
      if (r_clear_evt) begin
        r_state   <= ST_IDLE;
        r_pre     <= '0;
        r_running <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_start_evt && !sw.pause) begin
              r_state   <= ST_RUN;
              r_pre     <= '0;
              r_running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (r_pause_evt) begin
              r_state   <= ST_PAUSED;
              r_running <= 1'b0;
            end else if (r_pre == PRE_LAST) begin
              r_pre <= '0;
            end else begin
              r_pre <= r_pre + PRE_W'(1);
            end
          end
          ST_PAUSED: begin
            if (r_start_evt && !r_pause_evt) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_pre     <= '0;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  // Live counters and display copies; the display skips updates while held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_su       <= '0;
      r_st       <= '0;
      r_mu       <= '0;
      r_mt       <= '0;
      r_dsu      <= '0;
      r_dst      <= '0;
      r_dmu      <= '0;
      r_dmt      <= '0;
      r_lap_hold <= 1'b0;
    end else if (r_clear_evt) begin
      r_su       <= '0;
      r_st       <= '0;
      r_mu       <= '0;
      r_mt       <= '0;
      r_dsu      <= '0;
      r_dst      <= '0;
      r_dmu      <= '0;
      r_dmt      <= '0;
      r_lap_hold <= 1'b0;
    end else begin
      r_su       <= w_su_nxt;
      r_st       <= w_st_nxt;
      r_mu       <= w_mu_nxt;
      r_mt       <= w_mt_nxt;
      r_lap_hold <= w_hold_nxt;
      if (!w_hold_nxt) begin
        r_dsu <= w_su_nxt;
        r_dst <= w_st_nxt;
        r_dmu <= w_mu_nxt;
        r_dmt <= w_mt_nxt;
      end
    end
  end

  assign sw.tick_1hz = r_tick;
  assign sw.running  = r_running;
  assign sw.wrap     = r_wrap;
  assign sw.lap_hold = r_lap_hold;
  assign sw.sec_u    = r_dsu;
  assign sw.sec_t    = r_dst;
  assign sw.min_u    = r_dmu;
  assign sw.min_t    = r_dmt;
endmodule
